// File: rtl/tcore_param.sv
// Shared types for the lower-level memory arbiter.
// Provides the FSM state and transaction owner enums.
package tcore_param;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT_RES,
      RESP
   } arb_state_e;

   typedef enum logic {
      OWNER_I,
      OWNER_D
   } arb_owner_e;

endpackage

// File: rtl/lowx_mem_arbiter_if.sv
// Bundle of icache, dcache and memory-side signals of the arbiter.
// slave: arbiter side; master: caches and memory model side.
interface lowx_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 128
);
   logic              i_req_valid_i;
   logic [ADDR_W-1:0] i_req_addr_i;
   logic              i_res_valid_o;
   logic [LINE_W-1:0] i_res_data_o;
   logic              d_req_valid_i;
   logic [ADDR_W-1:0] d_req_addr_i;
   logic              d_req_rw_i;
   logic [LINE_W-1:0] d_req_data_i;
   logic              d_req_uncached_i;
   logic              d_res_valid_o;
   logic [LINE_W-1:0] d_res_data_o;
   logic              mem_req_valid_o;
   logic              mem_req_ready_i;
   logic [ADDR_W-1:0] mem_req_addr_o;
   logic              mem_req_rw_o;
   logic [LINE_W-1:0] mem_req_data_o;
   logic              mem_req_uncached_o;
   logic              mem_res_valid_i;
   logic [LINE_W-1:0] mem_res_data_i;
   logic              busy_o;

   modport slave (
      input  i_req_valid_i, i_req_addr_i,
      input  d_req_valid_i, d_req_addr_i,
      input  d_req_rw_i, d_req_data_i,
      input  d_req_uncached_i,
      input  mem_req_ready_i,
      input  mem_res_valid_i, mem_res_data_i,
      output i_res_valid_o, i_res_data_o,
      output d_res_valid_o, d_res_data_o,
      output mem_req_valid_o, mem_req_addr_o,
      output mem_req_rw_o, mem_req_data_o,
      output mem_req_uncached_o,
      output busy_o
   );

   modport master (
      output i_req_valid_i, i_req_addr_i,
      output d_req_valid_i, d_req_addr_i,
      output d_req_rw_i, d_req_data_i,
      output d_req_uncached_i,
      output mem_req_ready_i,
      output mem_res_valid_i, mem_res_data_i,
      input  i_res_valid_o, i_res_data_o,
      input  d_res_valid_o, d_res_data_o,
      input  mem_req_valid_o, mem_req_addr_o,
      input  mem_req_rw_o, mem_req_data_o,
      input  mem_req_uncached_o,
      input  busy_o
   );
endinterface

// File: rtl/lowx_arb_sel.sv
// Grant decision: dcache wins unless it also won last time.
// Ports: i_ivalid/i_dvalid/i_last in; o_gnt/o_owner out.
module lowx_arb_sel
   import tcore_param::*;
(
   input  logic       i_ivalid,
   input  logic       i_dvalid,
   input  arb_owner_e i_last,
   output logic       o_gnt,
   output arb_owner_e o_owner
);

   always_comb begin
      o_gnt   = i_ivalid | i_dvalid;
      o_owner = OWNER_I;
      // fetch gets the slot on a conflict right after a D grant
      if (i_dvalid && !(i_ivalid && i_last == OWNER_D))
         o_owner = OWNER_D;
   end

endmodule

// File: rtl/lowx_mem_arbiter.sv
// Shares one memory port between icache and dcache miss paths.
// Ports: clk_i, rst_i (sync, active high), bus (slave side).
module lowx_mem_arbiter
   import tcore_param::*;
#(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 128
) (
   input  logic             clk_i,
   input  logic             rst_i,
   lowx_mem_arbiter_if.slave bus
);

   arb_state_e        r_state;
   arb_owner_e        r_owner;
   arb_owner_e        r_last;
   logic [ADDR_W-1:0] r_addr;
   logic              r_rw;
   logic [LINE_W-1:0] r_data;
   logic              r_unc;
   logic              r_mreq_v;
   logic              r_ires_v;
   logic              r_dres_v;
   logic [LINE_W-1:0] r_ires_d;
   logic [LINE_W-1:0] r_dres_d;
   logic              r_busy;
   logic              w_gnt;
   arb_owner_e        w_owner;

   lowx_arb_sel u_sel (
      .i_ivalid (bus.i_req_valid_i),
      .i_dvalid (bus.d_req_valid_i),
      .i_last   (r_last),
      .o_gnt    (w_gnt),
      .o_owner  (w_owner)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state  <= IDLE;
         r_owner  <= OWNER_I;
         r_last   <= OWNER_I;
         r_addr   <= '0;
         r_rw     <= 1'b0;
         r_data   <= '0;
         r_unc    <= 1'b0;
         r_mreq_v <= 1'b0;
         r_ires_v <= 1'b0;
         r_dres_v <= 1'b0;
         r_ires_d <= '0;
         r_dres_d <= '0;
         r_busy   <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_gnt) begin
                  r_owner  <= w_owner;
                  r_last   <= w_owner;
                  r_mreq_v <= 1'b1;
                  r_busy   <= 1'b1;
                  r_state  <= REQ;
                  if (w_owner == OWNER_D) begin
                     r_addr <= bus.d_req_addr_i;
                     r_rw   <= bus.d_req_rw_i;
                     r_data <= bus.d_req_data_i;
                     r_unc  <= bus.d_req_uncached_i;
                  end else begin
                     r_addr <= bus.i_req_addr_i;
                     r_rw   <= 1'b0;
                     r_data <= '0;
                     r_unc  <= 1'b0;
                  end
               end
            end
            REQ: begin
               // a response coinciding with acceptance is dropped
               if (bus.mem_req_ready_i) begin
                  r_mreq_v <= 1'b0;
                  r_state  <= WAIT_RES;
               end
            end
            WAIT_RES: begin
               if (bus.mem_res_valid_i) begin
                  r_state <= RESP;
                  if (r_owner == OWNER_D) begin
                     r_dres_d <= bus.mem_res_data_i;
                     r_dres_v <= 1'b1;
                  end else begin
                     r_ires_d <= bus.mem_res_data_i;
                     r_ires_v <= 1'b1;
                  end
               end
            end
            RESP: begin
               r_ires_v <= 1'b0;
               r_dres_v <= 1'b0;
               r_busy   <= 1'b0;
               r_state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.i_res_valid_o      = r_ires_v;
   assign bus.i_res_data_o       = r_ires_d;
   assign bus.d_res_valid_o      = r_dres_v;
   assign bus.d_res_data_o       = r_dres_d;
   assign bus.mem_req_valid_o    = r_mreq_v;
   assign bus.mem_req_addr_o     = r_addr;
   assign bus.mem_req_rw_o       = r_rw;
   assign bus.mem_req_data_o     = r_data;
   assign bus.mem_req_uncached_o = r_unc;
   assign bus.busy_o             = r_busy;

endmodule

// File: tb/tb_lowx_mem_arbiter.sv
// Directed bench for lowx_mem_arbiter.
// Drives caches and memory through the interface, checks outputs.
module tb_lowx_mem_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;

   localparam logic [127:0] L1 = {4{32'h1111_1111}};
   localparam logic [127:0] LB = {4{32'hDEAD_BEEF}};
   localparam logic [127:0] L2 = {4{32'h2222_2222}};
   localparam logic [127:0] L3 = {4{32'h3333_3333}};
   localparam logic [127:0] L4 = {4{32'h4444_4444}};
   localparam logic [127:0] L5 = {4{32'h5555_5555}};

   always #5 clk = ~clk;

   lowx_mem_arbiter_if #(.ADDR_W(32), .LINE_W(128)) bus ();

   lowx_mem_arbiter #(.ADDR_W(32), .LINE_W(128)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [127:0] obs,
                      input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // one transaction from IDLE with the request(s) already driven
   task automatic txn(input string tag,
                      input logic [31:0] addr,
                      input logic is_d,
                      input logic [127:0] data);
      tick();
      chk({tag, "_addr"}, bus.mem_req_addr_o, addr);
      bus.mem_req_ready_i = 1'b1;
      tick();
      bus.mem_req_ready_i = 1'b0;
      bus.mem_res_valid_i = 1'b1;
      bus.mem_res_data_i  = data;
      tick();
      bus.mem_res_valid_i = 1'b0;
      chk({tag, "_dv"}, bus.d_res_valid_o, is_d);
      chk({tag, "_iv"}, bus.i_res_valid_o, !is_d);
      tick();
   endtask

   initial begin
      bus.i_req_valid_i    = 1'b0;
      bus.i_req_addr_i     = '0;
      bus.d_req_valid_i    = 1'b0;
      bus.d_req_addr_i     = '0;
      bus.d_req_rw_i       = 1'b0;
      bus.d_req_data_i     = '0;
      bus.d_req_uncached_i = 1'b0;
      bus.mem_req_ready_i  = 1'b0;
      bus.mem_res_valid_i  = 1'b0;
      bus.mem_res_data_i   = '0;
      tick();
      tick();
      chk("rst_mv", bus.mem_req_valid_o, 1'b0);
      chk("rst_busy", bus.busy_o, 1'b0);
      chk("rst_iv", bus.i_res_valid_o, 1'b0);
      chk("rst_dv", bus.d_res_valid_o, 1'b0);
      chk("rst_addr", bus.mem_req_addr_o, 32'h0);
      chk("rst_idata", bus.i_res_data_o, 128'h0);
      rst = 1'b0;

      // single icache read, ready together with valid
      bus.i_req_valid_i   = 1'b1;
      bus.i_req_addr_i    = 32'h8000_0040;
      bus.mem_req_ready_i = 1'b1;
      tick();
      chk("ic_mv", bus.mem_req_valid_o, 1'b1);
      chk("ic_addr", bus.mem_req_addr_o, 32'h8000_0040);
      chk("ic_rw", bus.mem_req_rw_o, 1'b0);
      chk("ic_busy", bus.busy_o, 1'b1);
      tick();
      bus.mem_req_ready_i = 1'b0;
      chk("ic_mv_drop", bus.mem_req_valid_o, 1'b0);
      tick();
      tick();
      bus.mem_res_valid_i = 1'b1;
      bus.mem_res_data_i  = L1;
      tick();
      bus.mem_res_valid_i = 1'b0;
      bus.i_req_valid_i   = 1'b0;
      chk("ic_iv", bus.i_res_valid_o, 1'b1);
      chk("ic_idata", bus.i_res_data_o, L1);
      chk("ic_dv", bus.d_res_valid_o, 1'b0);
      tick();
      chk("ic_iv_once", bus.i_res_valid_o, 1'b0);
      chk("ic_idle", bus.busy_o, 1'b0);

      // dcache writeback, ready low for 4 cycles
      bus.d_req_valid_i = 1'b1;
      bus.d_req_addr_i  = 32'h8000_1000;
      bus.d_req_rw_i    = 1'b1;
      bus.d_req_data_i  = LB;
      tick();
      for (int k = 0; k < 4; k++) begin
         chk("wb_mv", bus.mem_req_valid_o, 1'b1);
         chk("wb_addr", bus.mem_req_addr_o, 32'h8000_1000);
         chk("wb_rw", bus.mem_req_rw_o, 1'b1);
         chk("wb_data", bus.mem_req_data_o, LB);
         tick();
      end
      bus.mem_req_ready_i = 1'b1;
      tick();
      bus.mem_req_ready_i = 1'b0;
      bus.mem_res_valid_i = 1'b1;
      bus.mem_res_data_i  = L2;
      tick();
      bus.mem_res_valid_i = 1'b0;
      bus.d_req_valid_i   = 1'b0;
      bus.d_req_rw_i      = 1'b0;
      chk("wb_dv", bus.d_res_valid_o, 1'b1);
      chk("wb_iv", bus.i_res_valid_o, 1'b0);
      chk("wb_ihold", bus.i_res_data_o, L1);
      tick();
      chk("wb_dv_once", bus.d_res_valid_o, 1'b0);

      // simultaneous requests from reset: D, I, D, I
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.i_req_valid_i = 1'b1;
      bus.i_req_addr_i  = 32'h0000_0100;
      bus.d_req_valid_i = 1'b1;
      bus.d_req_addr_i  = 32'h0000_0200;
      txn("alt0_d", 32'h0000_0200, 1'b1, L3);
      chk("alt0_idle", bus.busy_o, 1'b0);
      txn("alt1_i", 32'h0000_0100, 1'b0, L4);
      txn("alt2_d", 32'h0000_0200, 1'b1, L3);
      txn("alt3_i", 32'h0000_0100, 1'b0, L4);
      bus.i_req_valid_i = 1'b0;
      bus.d_req_valid_i = 1'b0;
      chk("alt_idata", bus.i_res_data_o, L4);
      chk("alt_ddata", bus.d_res_data_o, L3);

      // uncached dcache read, icache arrives mid-transaction
      bus.d_req_valid_i    = 1'b1;
      bus.d_req_addr_i     = 32'h2000_0004;
      bus.d_req_uncached_i = 1'b1;
      tick();
      chk("unc_flag0", bus.mem_req_uncached_o, 1'b1);
      bus.i_req_valid_i = 1'b1;
      bus.i_req_addr_i  = 32'h0000_0300;
      tick();
      chk("unc_flag1", bus.mem_req_uncached_o, 1'b1);
      chk("unc_addr", bus.mem_req_addr_o, 32'h2000_0004);
      bus.mem_req_ready_i = 1'b1;
      tick();
      bus.mem_req_ready_i = 1'b0;
      bus.mem_res_valid_i = 1'b1;
      bus.mem_res_data_i  = L5;
      tick();
      bus.mem_res_valid_i  = 1'b0;
      bus.d_req_valid_i    = 1'b0;
      bus.d_req_uncached_i = 1'b0;
      chk("unc_dv", bus.d_res_valid_o, 1'b1);
      chk("unc_iv", bus.i_res_valid_o, 1'b0);
      tick();
      txn("unc_i", 32'h0000_0300, 1'b0, L2);
      chk("unc_i_unc", bus.mem_req_uncached_o, 1'b0);
      bus.i_req_valid_i = 1'b0;

      // reset in WAIT_RES, then a stale response
      bus.i_req_valid_i = 1'b1;
      bus.i_req_addr_i  = 32'h0000_0400;
      tick();
      bus.mem_req_ready_i = 1'b1;
      tick();
      bus.mem_req_ready_i = 1'b0;
      chk("rw_busy", bus.busy_o, 1'b1);
      rst = 1'b1;
      bus.i_req_valid_i = 1'b0;
      tick();
      rst = 1'b0;
      chk("rw_busy0", bus.busy_o, 1'b0);
      chk("rw_mv0", bus.mem_req_valid_o, 1'b0);
      tick();
      bus.mem_res_valid_i = 1'b1;
      bus.mem_res_data_i  = L5;
      tick();
      bus.mem_res_valid_i = 1'b0;
      chk("rw_iv", bus.i_res_valid_o, 1'b0);
      chk("rw_dv", bus.d_res_valid_o, 1'b0);
      chk("rw_busy1", bus.busy_o, 1'b0);
      chk("rw_idata", bus.i_res_data_o, 128'h0);
      bus.i_req_valid_i = 1'b1;
      bus.i_req_addr_i  = 32'h0000_0500;
      txn("rw_i", 32'h0000_0500, 1'b0, L3);
      bus.i_req_valid_i = 1'b0;
      chk("rw_idata2", bus.i_res_data_o, L3);

      // ready and response coincident in REQ
      bus.d_req_valid_i = 1'b1;
      bus.d_req_addr_i  = 32'h0000_0600;
      tick();
      bus.mem_req_ready_i = 1'b1;
      bus.mem_res_valid_i = 1'b1;
      bus.mem_res_data_i  = L1;
      tick();
      bus.mem_req_ready_i = 1'b0;
      bus.mem_res_valid_i = 1'b0;
      chk("co_dv0", bus.d_res_valid_o, 1'b0);
      chk("co_mv0", bus.mem_req_valid_o, 1'b0);
      chk("co_busy", bus.busy_o, 1'b1);
      tick();
      chk("co_dv1", bus.d_res_valid_o, 1'b0);
      bus.mem_res_valid_i = 1'b1;
      bus.mem_res_data_i  = L4;
      tick();
      bus.mem_res_valid_i = 1'b0;
      bus.d_req_valid_i   = 1'b0;
      chk("co_dv2", bus.d_res_valid_o, 1'b1);
      chk("co_ddata", bus.d_res_data_o, L4);
      tick();
      chk("co_dv3", bus.d_res_valid_o, 1'b0);
      chk("co_idle", bus.busy_o, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
